alt_vipitc130_common_frame_position_counter: RTL and testbench
==============================================================

ALT_VIPITC130_COMMON_FRAME_POSITION_COUNTER -- requirements
Module: alt_vipitc130_common_frame_position_counter

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 16, width of all position/timing values.
REQ-002 SHALL have parameters H_TOTAL_DEFAULT (1920), V_TOTAL_DEFAULT (1080), H_ACTIVE_DEFAULT (1920), V_ACTIVE_DEFAULT (1080): timing in force after rst.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port sclr  input  1  synchronous clear, active-high.
REQ-006 SHALL have port count_sample  input  1  one complete pixel sample consumed this cycle (driven by upstream sample counter).
REQ-007 SHALL have ports h_total_in, v_total_in, h_active_in, v_active_in  input  CTRL_WIDTH each  requested timing.
REQ-008 SHALL have port config_load  input  1  capture requested timing into pending registers.
REQ-009 SHALL have ports h_count, v_count  output  CTRL_WIDTH each  current sample/line position (registered).
REQ-010 SHALL have ports end_of_line, end_of_frame, start_of_frame, active_video  output  1 each  position flags (combinational from registered state).
REQ-011 SHALL have port config_pending  output  1  captured timing awaiting frame boundary (registered).

Function
REQ-012 SHALL hold timing in two register sets: pending (written by config_load) and in-force (used for counting).
REQ-013 SHALL, on config_load, capture all four *_in values into pending and set config_pending next cycle.
REQ-014 SHALL clamp any captured total or active value of 0 to 1; active values above their total SHALL be clamped to the total.
REQ-015 SHALL increment h_count by 1 on each cycle with count_sample=1 and h_count != h_total-1.
REQ-016 SHALL, on count_sample=1 with h_count == h_total-1, set h_count to 0 and advance v_count by 1, or wrap v_count to 0 when v_count == v_total-1.
REQ-017 SHALL hold h_count and v_count when count_sample=0.
REQ-018 SHALL drive end_of_line = count_sample & (h_count == h_total-1), same cycle.
REQ-019 SHALL drive end_of_frame = end_of_line & (v_count == v_total-1), same cycle.
REQ-020 SHALL drive start_of_frame = (h_count == 0) & (v_count == 0).
REQ-021 SHALL drive active_video = (h_count < h_active) & (v_count < v_active), using in-force values.
REQ-022 SHALL, on end_of_frame with config_pending=1 and config_load=0, copy pending into in-force and clear config_pending; the next frame uses new timing.
REQ-023 SHALL, on simultaneous end_of_frame and config_load, capture new values into pending, leave in-force unchanged and keep config_pending=1 (load wins; applied at following frame boundary).
REQ-024 SHALL, on sclr=1, set h_count=0, v_count=0, discard any coincident count_sample, copy pending into in-force if config_pending=1, clear config_pending.
REQ-025 SHALL, on sclr and config_load together, capture new values into pending and set config_pending=1 after the sclr-triggered copy of old pending.
REQ-026 SHALL compute all comparisons at CTRL_WIDTH bits with no overflow; h_count/v_count never exceed in-force total-1.
REQ-027 SHALL have 1-cycle latency from count_sample to updated h_count/v_count and zero-cycle latency for end_of_line/end_of_frame.

Reset
REQ-028 SHALL, on rst, asynchronously set h_count=0, v_count=0, config_pending=0, in-force and pending timing to the *_DEFAULT parameters.
REQ-029 SHALL, after rst, present start_of_frame=1, active_video=1, end_of_line=0, end_of_frame=0.
REQ-030 SHALL abort any frame in progress on rst mid-frame; no pending timing survives reset.

Verification
REQ-031 Bench SHALL load h_total=4,v_total=3,h_active=3,v_active=2 then sclr, drive 12 continuous count_sample -> h_count 0..3 repeating, end_of_line on samples 4,8,12, end_of_frame only on sample 12, counts return to 0,0.
REQ-032 Bench SHALL cover gapped input (count_sample 1-0-0-1) with h_total=4 -> counts advance only on asserted cycles, flags never assert while count_sample=0.
REQ-033 Bench SHALL config_load h_total=2 mid-frame -> config_pending=1, old h_total=4 governs until end_of_frame, then h_count wraps at 1 and config_pending=0.
REQ-034 Bench SHALL assert config_load in the end_of_frame cycle -> config_pending stays 1, new timing applies one frame later.
REQ-035 Bench SHALL load h_total_in=0,h_active_in=5,v_total_in=2 -> effective h_total=1, h_active=1; end_of_line on every sample.
REQ-036 Bench SHALL assert rst at h_count=2,v_count=1 with pending config -> next cycle h_count=0,v_count=0,config_pending=0, default timing (1920x1080) in force.

Source files
------------

// File: rtl/alt_vipitc130_common_frame_position_counter.sv
// -----------------------------------------------------------------------------
// alt_vipitc130_common_frame_position_counter
//
// Tracks the current sample (h_count) and line (v_count) position inside a
// video frame. Every cycle with count_sample=1 advances the position by one
// sample, wrapping at the end of each line and at the end of each frame.
//
// Timing is double-buffered. config_load captures the requested values into a
// pending set. The pending set only becomes the in-force set at a frame
// boundary (end_of_frame) or on a synchronous clear, so a frame is never
// counted with a mixture of old and new timing.
//
// Ports
//   rst             asynchronous active-high reset (defaults in force)
//   clk             clock, rising edge
//   sclr            synchronous clear: position to 0,0, apply pending timing
//   count_sample    one pixel sample consumed this cycle
//   h_total_in      requested samples per line
//   v_total_in      requested lines per frame
//   h_active_in     requested active samples per line
//   v_active_in     requested active lines per frame
//   config_load     capture the *_in values into the pending set
//   h_count         current sample position within the line (registered)
//   v_count         current line position within the frame (registered)
//   end_of_line     last sample of a line consumed this cycle
//   end_of_frame    last sample of a frame consumed this cycle
//   start_of_frame  position is 0,0
//   active_video    position lies inside the active region
//   config_pending  captured timing is waiting for a frame boundary
// -----------------------------------------------------------------------------
module alt_vipitc130_common_frame_position_counter #(
  parameter int CTRL_WIDTH       = 16,
  parameter int H_TOTAL_DEFAULT  = 1920,
  parameter int V_TOTAL_DEFAULT  = 1080,
  parameter int H_ACTIVE_DEFAULT = 1920,
  parameter int V_ACTIVE_DEFAULT = 1080
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  count_sample,
  input  logic [CTRL_WIDTH-1:0] h_total_in,
  input  logic [CTRL_WIDTH-1:0] v_total_in,
  input  logic [CTRL_WIDTH-1:0] h_active_in,
  input  logic [CTRL_WIDTH-1:0] v_active_in,
  input  logic                  config_load,
  output logic [CTRL_WIDTH-1:0] h_count,
  output logic [CTRL_WIDTH-1:0] v_count,
  output logic                  end_of_line,
  output logic                  end_of_frame,
  output logic                  start_of_frame,
  output logic                  active_video,
  output logic                  config_pending
);

  localparam logic [CTRL_WIDTH-1:0] ONE       = {{(CTRL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CTRL_WIDTH-1:0] H_TOT_RST = CTRL_WIDTH'(H_TOTAL_DEFAULT);
  localparam logic [CTRL_WIDTH-1:0] V_TOT_RST = CTRL_WIDTH'(V_TOTAL_DEFAULT);
  localparam logic [CTRL_WIDTH-1:0] H_ACT_RST = CTRL_WIDTH'(H_ACTIVE_DEFAULT);
  localparam logic [CTRL_WIDTH-1:0] V_ACT_RST = CTRL_WIDTH'(V_ACTIVE_DEFAULT);

  // A total of zero would make "total-1" underflow, so it is treated as 1.
  function automatic logic [CTRL_WIDTH-1:0] clamp_total(
    input logic [CTRL_WIDTH-1:0] t
  );
    return (t == '0) ? ONE : t;
  endfunction

  // Active region is at least one and never larger than the (clamped) total.
  function automatic logic [CTRL_WIDTH-1:0] clamp_active(
    input logic [CTRL_WIDTH-1:0] a,
    input logic [CTRL_WIDTH-1:0] t_clamped
  );
    logic [CTRL_WIDTH-1:0] r;
    if (a == '0) begin
      r = ONE;
    end else if (a > t_clamped) begin
      r = t_clamped;
    end else begin
      r = a;
    end
    return r;
  endfunction

  // Position state
  logic [CTRL_WIDTH-1:0] h_count_q, h_count_d;
  logic [CTRL_WIDTH-1:0] v_count_q, v_count_d;
  logic                  config_pending_q, config_pending_d;

  // In-force timing
  logic [CTRL_WIDTH-1:0] h_total_q, h_total_d;
  logic [CTRL_WIDTH-1:0] v_total_q, v_total_d;
  logic [CTRL_WIDTH-1:0] h_active_q, h_active_d;
  logic [CTRL_WIDTH-1:0] v_active_q, v_active_d;

  // Pending timing
  logic [CTRL_WIDTH-1:0] pend_h_total_q, pend_h_total_d;
  logic [CTRL_WIDTH-1:0] pend_v_total_q, pend_v_total_d;
  logic [CTRL_WIDTH-1:0] pend_h_active_q, pend_h_active_d;
  logic [CTRL_WIDTH-1:0] pend_v_active_q, pend_v_active_d;

  logic                  h_last;
  logic                  v_last;
  logic                  eol;
  logic                  eof;
  logic [CTRL_WIDTH-1:0] ld_h_total;
  logic [CTRL_WIDTH-1:0] ld_v_total;

  // Totals are always >= 1, so subtracting one cannot wrap.
  assign h_last = (h_count_q == (h_total_q - ONE));
  assign v_last = (v_count_q == (v_total_q - ONE));
  assign eol    = count_sample & h_last;
  assign eof    = eol & v_last;

  assign ld_h_total = clamp_total(h_total_in);
  assign ld_v_total = clamp_total(v_total_in);

  always_comb begin
    h_count_d        = h_count_q;
    v_count_d        = v_count_q;
    config_pending_d = config_pending_q;
    h_total_d        = h_total_q;
    v_total_d        = v_total_q;
    h_active_d       = h_active_q;
    v_active_d       = v_active_q;
    pend_h_total_d   = pend_h_total_q;
    pend_v_total_d   = pend_v_total_q;
    pend_h_active_d  = pend_h_active_q;
    pend_v_active_d  = pend_v_active_q;

    if (sclr) begin
      // Clear discards any coincident sample and applies waiting timing.
      h_count_d        = '0;
      v_count_d        = '0;
      config_pending_d = 1'b0;
      if (config_pending_q) begin
        h_total_d  = pend_h_total_q;
        v_total_d  = pend_v_total_q;
        h_active_d = pend_h_active_q;
        v_active_d = pend_v_active_q;
      end
    end else begin
      if (count_sample) begin
        if (h_last) begin
          h_count_d = '0;
          v_count_d = v_last ? '0 : (v_count_q + ONE);
        end else begin
          h_count_d = h_count_q + ONE;
        end
      end
      // A load in the boundary cycle wins: the older pending set is replaced
      // and nothing is applied until the following frame boundary.
      if (eof && config_pending_q && !config_load) begin
        h_total_d        = pend_h_total_q;
        v_total_d        = pend_v_total_q;
        h_active_d       = pend_h_active_q;
        v_active_d       = pend_v_active_q;
        config_pending_d = 1'b0;
      end
    end

    // The capture is ordered after any sclr-triggered copy of the old set.
    if (config_load) begin
      pend_h_total_d   = ld_h_total;
      pend_v_total_d   = ld_v_total;
      pend_h_active_d  = clamp_active(h_active_in, ld_h_total);
      pend_v_active_d  = clamp_active(v_active_in, ld_v_total);
      config_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count_q        <= '0;
      v_count_q        <= '0;
      config_pending_q <= 1'b0;
      h_total_q        <= H_TOT_RST;
      v_total_q        <= V_TOT_RST;
      h_active_q       <= H_ACT_RST;
      v_active_q       <= V_ACT_RST;
      pend_h_total_q   <= H_TOT_RST;
      pend_v_total_q   <= V_TOT_RST;
      pend_h_active_q  <= H_ACT_RST;
      pend_v_active_q  <= V_ACT_RST;
    end else begin
      h_count_q        <= h_count_d;
      v_count_q        <= v_count_d;
      config_pending_q <= config_pending_d;
      h_total_q        <= h_total_d;
      v_total_q        <= v_total_d;
      h_active_q       <= h_active_d;
      v_active_q       <= v_active_d;
      pend_h_total_q   <= pend_h_total_d;
      pend_v_total_q   <= pend_v_total_d;
      pend_h_active_q  <= pend_h_active_d;
      pend_v_active_q  <= pend_v_active_d;
    end
  end

  assign h_count        = h_count_q;
  assign v_count        = v_count_q;
  assign config_pending = config_pending_q;
  assign end_of_line    = eol;
  assign end_of_frame   = eof;
  assign start_of_frame = (h_count_q == '0) & (v_count_q == '0);
  assign active_video   = (h_count_q < h_active_q) & (v_count_q < v_active_q);

endmodule

// File: tb/tb_alt_vipitc130_common_frame_position_counter.sv
// Testbench: the reference model keeps a linear sample index within the frame
// and derives line/sample position from it with division and modulo.
module tb_alt_vipitc130_common_frame_position_counter;

  localparam int W = 16;

  logic         rst;
  logic         clk;
  logic         sclr;
  logic         count_sample;
  logic [W-1:0] h_total_in, v_total_in, h_active_in, v_active_in;
  logic         config_load;
  logic [W-1:0] h_count, v_count;
  logic         end_of_line, end_of_frame, start_of_frame, active_video;
  logic         config_pending;

  alt_vipitc130_common_frame_position_counter #(
    .CTRL_WIDTH(W)
  ) dut (
    .rst            (rst),
    .clk            (clk),
    .sclr           (sclr),
    .count_sample   (count_sample),
    .h_total_in     (h_total_in),
    .v_total_in     (v_total_in),
    .h_active_in    (h_active_in),
    .v_active_in    (v_active_in),
    .config_load    (config_load),
    .h_count        (h_count),
    .v_count        (v_count),
    .end_of_line    (end_of_line),
    .end_of_frame   (end_of_frame),
    .start_of_frame (start_of_frame),
    .active_video   (active_video),
    .config_pending (config_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ht;
    int vt;
    int ha;
    int va;
  } timing_t;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] v;
    logic         cp;
    logic         eol;
    logic         eof;
    logic         sof;
    logic         av;
  } exp_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      txn    = 0;
  bit      verbose = 1'b1;

  // Reference model state
  timing_t m_force, m_pend;
  bit      m_cp;
  int      m_pos;

  function automatic timing_t defaults();
    timing_t t;
    t.ht = 1920; t.vt = 1080; t.ha = 1920; t.va = 1080;
    return t;
  endfunction

  function automatic timing_t clamp(int ht, int vt, int ha, int va);
    timing_t t;
    t.ht = (ht == 0) ? 1 : ht;
    t.vt = (vt == 0) ? 1 : vt;
    t.ha = (ha == 0) ? 1 : ((ha > t.ht) ? t.ht : ha);
    t.va = (va == 0) ? 1 : ((va > t.vt) ? t.vt : va);
    return t;
  endfunction

  function automatic bit at_frame_last();
    return m_pos == m_force.ht * m_force.vt - 1;
  endfunction

  function automatic int cur_h();
    return m_pos % m_force.ht;
  endfunction

  function automatic int cur_v();
    return m_pos / m_force.ht;
  endfunction

  // One clock of stimulus: drive, predict this cycle's outputs, advance model.
  task automatic step(bit cs, bit ld, bit sc, int ht, int vt, int ha, int va);
    exp_t e;
    int   h, v;
    bit   eol, eof;
    @(posedge clk);
    #1;
    count_sample = cs;
    config_load  = ld;
    sclr         = sc;
    h_total_in   = W'(ht);
    v_total_in   = W'(vt);
    h_active_in  = W'(ha);
    v_active_in  = W'(va);

    h   = cur_h();
    v   = cur_v();
    eol = cs && (h == m_force.ht - 1);
    eof = eol && (v == m_force.vt - 1);
    e.h   = W'(h);
    e.v   = W'(v);
    e.cp  = m_cp;
    e.eol = eol;
    e.eof = eof;
    e.sof = (m_pos == 0);
    e.av  = (h < m_force.ha) && (v < m_force.va);
    exp_q.push_back(e);

    if (sc) begin
      m_pos = 0;
      if (m_cp) m_force = m_pend;
      m_cp = 0;
    end else begin
      if (cs) m_pos = (m_pos + 1) % (m_force.ht * m_force.vt);
      if (eof && m_cp && !ld) begin
        m_force = m_pend;
        m_cp    = 0;
      end
    end
    if (ld) begin
      m_pend = clamp(ht, vt, ha, va);
      m_cp   = 1;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic samples(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(int ht, int vt, int ha, int va);
    step(0, 1, 0, ht, vt, ha, va);
  endtask

  task automatic clear();
    step(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst          = 1'b1;
    count_sample = 1'b0;
    config_load  = 1'b0;
    sclr         = 1'b0;
    m_force = defaults();
    m_pend  = defaults();
    m_cp    = 0;
    m_pos   = 0;
    #1;
    // Reset acts without a clock edge.
    checks++;
    if (h_count !== '0 || v_count !== '0 || config_pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got h=%0d v=%0d cp=%0b, want h=0 v=0 cp=0",
               h_count, v_count, config_pending);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every clock the DUT presents a position, compare against queue.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.h = h_count; a.v = v_count; a.cp = config_pending;
        a.eol = end_of_line; a.eof = end_of_frame;
        a.sof = start_of_frame; a.av = active_video;
        checks++;
        txn++;
        if (a !== e) begin
          errors++;
          $display("FAIL txn%0d position: got h=%0d v=%0d cp=%0b eol=%0b eof=%0b sof=%0b av=%0b, want h=%0d v=%0d cp=%0b eol=%0b eof=%0b sof=%0b av=%0b",
                   txn, a.h, a.v, a.cp, a.eol, a.eof, a.sof, a.av,
                   e.h, e.v, e.cp, e.eol, e.eof, e.sof, e.av);
        end else if (verbose) begin
          $display("txn%0d h=%0d v=%0d cp=%0b eol=%0b eof=%0b sof=%0b av=%0b",
                   txn, a.h, a.v, a.cp, a.eol, a.eof, a.sof, a.av);
        end
      end
    end
  end

  initial begin
    int ht, vt, ha, va;
    int guard;
    rst          = 1'b1;
    sclr         = 1'b0;
    count_sample = 1'b0;
    config_load  = 1'b0;
    h_total_in   = '0;
    v_total_in   = '0;
    h_active_in  = '0;
    v_active_in  = '0;
    m_force = defaults();
    m_pend  = defaults();
    m_cp    = 0;
    m_pos   = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: sof=1, av=1, no flags.
    idle(2);

    // 4x3 frame, active 3x2, 12 continuous samples = one full frame.
    load(4, 3, 3, 2);
    clear();
    samples(12);
    idle(1);

    // Gapped input 1-0-0-1.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0);
    end

    // Mid-frame load of h_total=2: old timing runs to the frame end.
    clear();
    samples(5);
    load(2, 3, 3, 2);
    guard = 0;
    while (!at_frame_last() && guard < 50) begin
      step(1, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    samples(8);

    // Load in the end_of_frame cycle: pending stays set, one frame later.
    load(3, 2, 2, 1);
    clear();
    load(4, 2, 4, 2);
    guard = 0;
    while (!at_frame_last() && guard < 50) begin
      step(1, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    step(1, 1, 0, 2, 2, 1, 1);
    guard = 0;
    while (!at_frame_last() && guard < 50) begin
      step(1, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    samples(6);

    // Zero total and oversized active are clamped.
    load(0, 2, 5, 1);
    clear();
    samples(6);

    // Reset mid-frame with pending configuration.
    load(4, 3, 3, 2);
    clear();
    samples(6);
    load(5, 5, 5, 5);
    idle(1);
    apply_reset();
    idle(1);
    // Default 1920 samples per line must be in force.
    verbose = 1'b0;
    samples(1925);
    verbose = 1'b1;
    idle(1);

    // Randomized traffic with small timings.
    load(3, 2, 2, 1);
    clear();
    for (int i = 0; i < 400; i++) begin
      ht = $urandom_range(0, 6);
      vt = $urandom_range(0, 4);
      ha = $urandom_range(0, 8);
      va = $urandom_range(0, 6);
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 6)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
           ht, vt, ha, va);
    end
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
